// File: rtl/mmio_stream_port_pkg.sv
// Shared register map, STATUS/CTRL bit positions and reset constants for mmio_stream_port.
package mmio_stream_port_pkg;

  typedef enum logic [1:0] {
    REG_RXDATA = 2'd0,
    REG_TXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } regOff_e;

  localparam int unsigned ST_RX_NONEMPTY  = 0;
  localparam int unsigned ST_RX_FULL      = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_TX_FULL      = 3;
  localparam int unsigned ST_RX_OVR       = 4;
  localparam int unsigned ST_TX_OVF       = 5;
  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_COUNT_LSB = 16;

  localparam int unsigned CTRL_RX_EN = 0;
  localparam int unsigned CTRL_TX_EN = 1;
  localparam logic [1:0]  CTRL_RESET = 2'b11;

  typedef struct packed {
    logic       rxNonEmpty;
    logic       rxFull;
    logic       txEmpty;
    logic       txFull;
    logic       rxOvr;
    logic       txOvf;
    logic [7:0] rxCount;
    logic [7:0] txCount;
  } status_t;

  function automatic logic [31:0] packStatus(input status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_RX_NONEMPTY]            = s.rxNonEmpty;
    w[ST_RX_FULL]                = s.rxFull;
    w[ST_TX_EMPTY]               = s.txEmpty;
    w[ST_TX_FULL]                = s.txFull;
    w[ST_RX_OVR]                 = s.rxOvr;
    w[ST_TX_OVF]                 = s.txOvf;
    w[ST_RX_COUNT_LSB +: 8]      = s.rxCount;
    w[ST_TX_COUNT_LSB +: 8]      = s.txCount;
    return w;
  endfunction

endpackage

// File: rtl/mmio_stream_port_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count, zero head when empty and a
// look-ahead full flag for registered ready generation.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iPush,
  input  logic [WIDTH-1:0]         iData,
  input  logic                     iPop,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic                     oFullNext,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic [WIDTH-1:0]         oHead
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic [AW:0]      countNext;
  logic             pushEff;
  logic             popEff;

  assign oFull   = (count == FULL_COUNT);
  assign oEmpty  = (count == '0);
  // Full/empty are judged on the registered count, so a push to a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign pushEff = iPush && !oFull;
  assign popEff  = iPop && !oEmpty;

  always_comb begin
    countNext = count;
    case ({pushEff, popEff})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  assign oFullNext = (countNext == FULL_COUNT);
  assign oCount    = count;
  assign oHead     = oEmpty ? '0 : mem[rdPtr];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushEff) wrPtr <= wrPtr + 1'b1;
      if (popEff)  rdPtr <= rdPtr + 1'b1;
      count <= countNext;
    end
  end

  always_ff @(posedge iCLK) begin
    if (pushEff) mem[wrPtr] <= iData;
  end

endmodule

// File: rtl/mmio_stream_port.sv
// Memory-mapped byte-stream port: RX FIFO read by software loads (pop-once per
// access), TX FIFO filled by software stores and drained to a valid/ready stream.
module mmio_stream_port
  import mmio_stream_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] DwReadData,
  output logic        oHit,
  input  logic        iRxValid,
  input  logic [7:0]  iRxData,
  output logic        oRxReady,
  output logic        oTxValid,
  output logic [7:0]  oTxData,
  input  logic        iTxReady
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  regOff_e     regOff;
  logic        rxRdHit;
  logic        txWr;
  logic        statusWr;
  logic        ctrlWr;

  logic        rxPush;
  logic        rxPop;
  logic        rxFull;
  logic        rxEmpty;
  logic        rxFullNext;
  logic [CW-1:0] rxCount;
  logic [7:0]  rxHead;

  logic        txPop;
  logic        txFull;
  logic        txEmpty;
  logic        txFullNext;
  logic [CW-1:0] txCount;
  logic [7:0]  txHead;

  logic [1:0]  ctrl;
  logic        rxEnNext;
  logic        rxOvr;
  logic        txOvf;
  logic        rxOvrSet;
  logic        txOvfSet;
  logic        rdAct;
  logic        holdValid;
  logic [7:0]  rdHold;
  status_t     status;
  logic        unusedBits;

  assign oHit     = (DwAddress[31:4] == BASE_ADDR[31:4]);
  assign regOff   = regOff_e'(DwAddress[3:2]);
  assign rxRdHit  = oHit && DwReadEnable && (regOff == REG_RXDATA);
  assign txWr     = oHit && DwWriteEnable && DwByteEnable[0] && (regOff == REG_TXDATA);
  assign statusWr = oHit && DwWriteEnable && DwByteEnable[0] && (regOff == REG_STATUS);
  assign ctrlWr   = oHit && DwWriteEnable && DwByteEnable[0] && (regOff == REG_CTRL);

  assign rxPush   = iRxValid && oRxReady;
  assign rxPop    = rxRdHit && !rdAct;
  assign rxOvrSet = iRxValid && ctrl[CTRL_RX_EN] && !oRxReady;
  assign txOvfSet = txWr && txFull;
  assign oTxValid = ctrl[CTRL_TX_EN] && !txEmpty;
  assign oTxData  = txHead;
  assign txPop    = oTxValid && iTxReady;
  assign rxEnNext = ctrlWr ? DwWriteData[CTRL_RX_EN] : ctrl[CTRL_RX_EN];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) uRxFifo (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iPush     (rxPush),
    .iData     (iRxData),
    .iPop      (rxPop),
    .oFull     (rxFull),
    .oEmpty    (rxEmpty),
    .oFullNext (rxFullNext),
    .oCount    (rxCount),
    .oHead     (rxHead)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) uTxFifo (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iPush     (txWr),
    .iData     (DwWriteData[7:0]),
    .iPop      (txPop),
    .oFull     (txFull),
    .oEmpty    (txEmpty),
    .oFullNext (txFullNext),
    .oCount    (txCount),
    .oHead     (txHead)
  );

  // The first cycle of an RXDATA access pops and latches the head; the rest of
  // the access replays the latched word so a stalled load sees a stable value.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rdAct     <= 1'b0;
      rdHold    <= '0;
      holdValid <= 1'b0;
    end else begin
      rdAct <= rxRdHit;
      if (rxPop) begin
        rdHold    <= rxHead;
        holdValid <= !rxEmpty;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ctrl     <= CTRL_RESET;
      rxOvr    <= 1'b0;
      txOvf    <= 1'b0;
      oRxReady <= 1'b0;
    end else begin
      if (ctrlWr) ctrl <= DwWriteData[1:0];
      rxOvr    <= rxOvrSet || (rxOvr && !(statusWr && DwWriteData[ST_RX_OVR]));
      txOvf    <= txOvfSet || (txOvf && !(statusWr && DwWriteData[ST_TX_OVF]));
      oRxReady <= rxEnNext && !rxFullNext;
    end
  end

  always_comb begin
    status            = '0;
    status.rxNonEmpty = !rxEmpty;
    status.rxFull     = rxFull;
    status.txEmpty    = txEmpty;
    status.txFull     = txFull;
    status.rxOvr      = rxOvr;
    status.txOvf      = txOvf;
    status.rxCount    = 8'(rxCount);
    status.txCount    = 8'(txCount);
  end

  always_comb begin
    DwReadData = '0;
    if (oHit) begin
      unique case (regOff)
        REG_RXDATA: DwReadData = rdAct ? {holdValid, 23'b0, rdHold}
                                       : {!rxEmpty, 23'b0, rxHead};
        REG_TXDATA: DwReadData = '0;
        REG_STATUS: DwReadData = packStatus(status);
        REG_CTRL:   DwReadData = {30'b0, ctrl};
      endcase
    end
  end

  assign unusedBits = ^{DwAddress[1:0], DwByteEnable[3:1], DwWriteData[31:8], txFullNext};

endmodule
